// File: rtl/sigmoid_ALU_pkg.sv
// Shared types and constants for the sigmoid ALU neuron accumulator.
// The limits are for the default 14-bit accumulator.
package sigmoid_ALU_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    localparam int         ACC_W_DEF = 14;
    localparam int         ACC_MAX   = 8191;
    localparam int         ACC_MIN   = -8192;
    localparam logic [3:0] ACT_MAX   = 4'd8;

endpackage

// File: rtl/sigmoid_ALU_mac_saturate.sv
// Combinational MAC step: clamps the activation, multiplies it by the signed
// weight, and adds the product to the accumulator with saturation.
module sigmoid_ALU_mac_saturate
    import sigmoid_ALU_pkg::*;
#(
    parameter int ACC_W = 14
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [3:0]       weight,
    input  logic        [3:0]       activation,
    output logic signed [ACC_W-1:0] acc_next
);

    localparam logic [ACC_W-1:0] SAT_HI = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_LO = {1'b1, {(ACC_W-1){1'b0}}};

    logic [3:0]         act_clamp_s;
    logic signed [8:0]  weight_ext_s;
    logic signed [8:0]  act_ext_s;
    logic signed [8:0]  prod_s;
    logic [ACC_W:0]     sum_s;

    // Clamp, multiply, and saturating add; overflow is seen as a mismatch of the two top sum bits.
    always_comb begin
        if (activation > ACT_MAX) begin
            act_clamp_s = ACT_MAX;
        end else begin
            act_clamp_s = activation;
        end
        weight_ext_s = {{5{weight[3]}}, weight};
        act_ext_s    = {5'd0, act_clamp_s};
        prod_s       = weight_ext_s * act_ext_s;
        sum_s        = {acc[ACC_W-1], acc} + {{(ACC_W-8){prod_s[8]}}, prod_s};
        if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
            if (sum_s[ACC_W]) begin
                acc_next = SAT_LO;
            end else begin
                acc_next = SAT_HI;
            end
        end else begin
            acc_next = sum_s[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/sigmoid_alu_neuron_accumulator.sv
// Per-neuron multiply-accumulate front end: latches the bias, sums N_INPUTS
// weight x activation beats, then hands accum/bias downstream via valid/ready.
module sigmoid_alu_neuron_accumulator
    import sigmoid_ALU_pkg::*;
#(
    parameter int N_INPUTS = 784,
    parameter int ACC_W    = 14
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start,
    input  logic signed [3:0]       bias_in,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [3:0]       weight,
    input  logic        [3:0]       activation,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] accum,
    output logic signed [3:0]       bias,
    output logic                    busy
);

    localparam logic [9:0] LAST_CNT = 10'(N_INPUTS - 1);

    acc_state_t              state_r;
    acc_state_t              state_next_s;
    logic [9:0]              cnt_r;
    logic signed [ACC_W-1:0] accum_r;
    logic signed [3:0]       bias_r;
    logic signed [ACC_W-1:0] acc_next_s;

    sigmoid_ALU_mac_saturate #(
        .ACC_W (ACC_W)
    ) u_mac (
        .acc        (accum_r),
        .weight     (weight),
        .activation (activation),
        .acc_next   (acc_next_s)
    );

    // State register; clear acts as the synchronous return to IDLE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; the last accepted beat is the one seen while the counter holds N_INPUTS-1.
    always_comb begin
        state_next_s = state_r;
        if (clear) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_next_s = ACCUM;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                ACCUM: begin
                    if (in_valid && (cnt_r == LAST_CNT)) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = ACCUM;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = DONE;
                    end
                end
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Handshake outputs depend on the state register alone.
    always_comb begin
        in_ready  = (state_r == ACCUM);
        out_valid = (state_r == DONE);
        busy      = (state_r != IDLE);
    end

    // Datapath registers: bias latch, beat counter and saturating accumulator.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_r   <= 10'd0;
            accum_r <= {ACC_W{1'b0}};
            bias_r  <= 4'sd0;
        end else if (clear) begin
            cnt_r   <= 10'd0;
            accum_r <= {ACC_W{1'b0}};
            bias_r  <= 4'sd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        cnt_r   <= 10'd0;
                        accum_r <= {ACC_W{1'b0}};
                        bias_r  <= bias_in;
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        cnt_r   <= cnt_r + 10'd1;
                        accum_r <= acc_next_s;
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign accum = accum_r;
    assign bias  = bias_r;

endmodule
